text_console_writer: RTL

Character-stream front end for the 80x30 text display. Accepts 8-bit ASCII bytes over a valid/ready handshake, interprets a small set of control codes, and writes 7-bit character codes into the write port of the dual-port tile RAM (address {row[4:0], col[6:0]}). It owns the cursor and publishes it to the text screen generator, replacing the switch/button-driven cursor with a terminal-style writer that can be fed from a UART receiver or a soft CPU.

---
 rtl/text_console_writer.sv | 90 +++++++++
 1 files changed

// File: rtl/text_console_writer.sv
// text_console_writer: turns an ASCII byte stream into character writes for the 80x30 tile RAM
// Ports: clk, reset (synchronous, active-high)
//        char_valid/char_data/char_ready - byte input handshake, ready only while idle
//        ram_we/ram_addr/ram_din         - tile RAM write port, address {row[4:0], col[6:0]}
//        cur_x/cur_y                     - cursor position published to the screen generator
//        busy                            - high while a row or full-screen clear is running
module text_console_writer #(
    parameter int CLEAR_ON_RESET = 1,
    parameter int MAX_X = 80,
    parameter int MAX_Y = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       ram_we,
    output logic [11:0] ram_addr,
    output logic [6:0] ram_din,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y,
    output logic       busy
);
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
    localparam logic [6:0] LAST_X = 7'(MAX_X - 1);
    localparam logic [4:0] LAST_Y = 5'(MAX_Y - 1);
    localparam logic [6:0] SPACE = 7'h20;
    state_t state, state_nxt;
    logic [6:0] clr_x;
    logic [4:0] clr_y;
    logic [4:0] next_y;
    logic printable, is_lf, is_cr, is_bs, is_ff, newline, clr_last;
    always_comb begin
        printable = char_data >= 8'h20 && char_data <= 8'h7E;
        is_lf = char_data == 8'h0A;
        is_cr = char_data == 8'h0D;
        is_bs = char_data == 8'h08;
        is_ff = char_data == 8'h0C;
        // a printable in the last column wraps exactly like LF
        newline = (printable && cur_x == LAST_X) || is_lf;
        next_y = cur_y == LAST_Y ? 5'd0 : cur_y + 5'd1;
        // a row clear ends on its last column; a full clear also needs the last row
        clr_last = clr_x == LAST_X && (state == CLR_ROW || clr_y == LAST_Y);
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= CLEAR_ON_RESET != 0 ? CLR_ALL : IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state != IDLE ? (clr_last ? IDLE : state)
                  : !char_valid ? IDLE
                  : newline ? CLR_ROW
                  : is_ff ? CLR_ALL : IDLE;
    end
    always_comb begin
        char_ready = state == IDLE;
        busy = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x <= 7'd0;
            cur_y <= 5'd0;
            ram_we <= 1'b0;
            ram_addr <= 12'd0;
            ram_din <= 7'd0;
            clr_x <= 7'd0;
            clr_y <= 5'd0;
        end else if (state != IDLE) begin
            // clear counters return to zero as each clear finishes, ready for the next one
            ram_we <= 1'b1;
            ram_addr <= {state == CLR_ROW ? cur_y : clr_y, clr_x};
            ram_din <= SPACE;
            clr_x <= clr_x == LAST_X ? 7'd0 : clr_x + 7'd1;
            clr_y <= (state == CLR_ROW || clr_x != LAST_X) ? clr_y
                   : clr_y == LAST_Y ? 5'd0 : clr_y + 5'd1;
        end else begin
            ram_we <= char_valid && (printable || (is_bs && cur_x != 7'd0));
            ram_addr <= {cur_y, printable ? cur_x : cur_x - 7'd1};
            ram_din <= printable ? char_data[6:0] : SPACE;
            if (char_valid) begin
                cur_x <= (newline || is_cr || is_ff) ? 7'd0
                       : printable ? cur_x + 7'd1
                       : (is_bs && cur_x != 7'd0) ? cur_x - 7'd1 : cur_x;
                cur_y <= is_ff ? 5'd0 : newline ? next_y : cur_y;
            end
        end
    end
endmodule
